ram_arbiter: RTL and testbench

//   Shares the single byte-addressed data RAM between two requesters: port A
//   (CPU load/store) and port B (program loader / debug). Serialises accesses

---
 rtl/ram_arbiter.sv | 126 ++++++++++++
 tb/tb_ram_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single 32-bit data RAM.
// Partial-word stores are done as read-modify-write: IDLE -> READ -> [WRITE] -> RESP.
module ram_arbiter #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [31:0]           a_wdata,
   input  logic [3:0]            a_be,
   output logic                  a_ack,
   output logic [31:0]           a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [31:0]           b_wdata,
   input  logic [3:0]            b_be,
   output logic                  b_ack,
   output logic [31:0]           b_rdata,
   output logic [ADDR_WIDTH-1:0] ram_read_addr,
   output logic [ADDR_WIDTH-1:0] ram_write_addr,
   output logic [31:0]           ram_din,
   input  logic [31:0]           ram_dout,
   output logic                  ram_write_en,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic                  r_rr_ptr;
   logic                  r_gnt;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_be;
   logic [31:0]           r_rbuf;
   logic [31:0]           r_merged;

   logic                  w_grant_valid;
   logic                  w_grant_id;
   logic [31:0]           w_merged;

   // Port id: 0 = A, 1 = B. With both requesting, the round-robin pointer decides.
   always_comb begin
      w_grant_valid = a_req | b_req;
      w_grant_id    = 1'b0;
      if (a_req && b_req) begin
         w_grant_id = r_rr_ptr;
      end else if (b_req) begin
         w_grant_id = 1'b1;
      end
   end

   always_comb begin
      w_merged = 32'd0;
      for (int i = 0; i < 4; i++) begin
         w_merged[8*i +: 8] = r_be[i] ? r_wdata[8*i +: 8] : ram_dout[8*i +: 8];
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_grant_valid) w_next_state = S_READ;
         S_READ:  w_next_state = (r_we && (r_be != 4'd0)) ? S_WRITE : S_RESP;
         S_WRITE: w_next_state = S_RESP;
         S_RESP:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= 1'b0;
         r_gnt    <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= 32'd0;
         r_be     <= 4'd0;
         r_rbuf   <= 32'd0;
         r_merged <= 32'd0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            S_IDLE: begin
               if (w_grant_valid) begin
                  r_gnt   <= w_grant_id;
                  r_we    <= w_grant_id ? b_we    : a_we;
                  r_addr  <= w_grant_id ? b_addr  : a_addr;
                  r_wdata <= w_grant_id ? b_wdata : a_wdata;
                  r_be    <= w_grant_id ? b_be    : a_be;
               end
            end
            S_READ: begin
               r_rbuf   <= ram_dout;
               r_merged <= w_merged;
            end
            S_RESP:  r_rr_ptr <= ~r_gnt;
            default: ;
         endcase
      end
   end

   // Address/data pins follow the latched request, so they hold while idle.
   assign ram_read_addr  = r_addr;
   assign ram_write_addr = r_addr;
   assign ram_din        = r_merged;
   assign ram_write_en   = (r_state == S_WRITE) && !rst;
   assign busy           = (r_state != S_IDLE);

   assign a_ack   = (r_state == S_RESP) && !r_gnt;
   assign b_ack   = (r_state == S_RESP) &&  r_gnt;
   assign a_rdata = a_ack ? r_rbuf : 32'd0;
   assign b_rdata = b_ack ? r_rbuf : 32'd0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed requests push expected acks,
// a negedge monitor pops and checks port, latency and read data.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, a_we, b_req, b_we;
   logic [11:0] a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic [3:0]  a_be, b_be;
   logic        a_ack, b_ack;
   logic [31:0] a_rdata, b_rdata;
   logic [11:0] ram_read_addr, ram_write_addr;
   logic [31:0] ram_din, ram_dout;
   logic        ram_write_en, busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int wr_cnt   = 0;

   logic [31:0] mem [0:1023];

   typedef struct {
      bit          port;
      logic [31:0] rdata;
      bit          chk_rdata;
      int          cyc;
   } exp_t;
   exp_t exp_q[$];

   ram_arbiter #(.ADDR_WIDTH(12)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_write_en(ram_write_en),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign ram_dout = mem[ram_read_addr[11:2]];
   always @(posedge clk) begin
      if (ram_write_en) begin
         mem[ram_write_addr[11:2]] <= ram_din;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("ack_overlap", {31'd0, a_ack & b_ack}, 32'd0);
         if (!a_ack) chk("a_rdata_idle", a_rdata, 32'd0);
         if (!b_ack) chk("b_rdata_idle", b_rdata, 32'd0);
         if (a_ack || b_ack) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", {30'd0, b_ack, a_ack}, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("ack_port", {31'd0, b_ack}, {31'd0, e.port});
               chk("ack_cycle", cyc, e.cyc);
               if (e.chk_rdata) chk("rdata", b_ack ? b_rdata : a_rdata, e.rdata);
            end
         end
      end
   end

   task automatic issue(input bit port, input bit we, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rd, input bit chk_rd, input int lat);
      exp_t e;
      bit   got;
      @(negedge clk);
      e.port = port; e.rdata = exp_rd; e.chk_rdata = chk_rd; e.cyc = cyc + lat;
      exp_q.push_back(e);
      if (!port) begin
         a_we = we; a_addr = addr; a_wdata = wdata; a_be = be; a_req = 1'b1;
      end else begin
         b_we = we; b_addr = addr; b_wdata = wdata; b_be = be; b_req = 1'b1;
      end
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (port ? b_ack : a_ack) begin
            got = 1'b1;
            break;
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      chk("ack_timeout", {31'd0, got}, 32'd1);
   endtask

   initial begin
      int w0;
      int acks;
      rst = 1'b1;
      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_be = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_be = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_a_ack", {31'd0, a_ack}, 32'd0);
      chk("rst_b_ack", {31'd0, b_ack}, 32'd0);
      chk("rst_a_rdata", a_rdata, 32'd0);
      chk("rst_b_rdata", b_rdata, 32'd0);
      chk("rst_write_en", {31'd0, ram_write_en}, 32'd0);

      // preload through the arbiter itself (prior contents unknown, rdata unchecked)
      issue(0, 1, 12'h010, 32'h44332211, 4'hF, 32'd0, 0, 3);
      issue(0, 1, 12'h030, 32'h12345678, 4'hF, 32'd0, 0, 3);
      issue(1, 1, 12'h040, 32'hA0A0A0A0, 4'hF, 32'd0, 0, 3);
      issue(1, 1, 12'h044, 32'hB1B1B1B1, 4'hF, 32'd0, 0, 3);
      issue(0, 1, 12'h050, 32'h0BADF00D, 4'hF, 32'd0, 0, 3);

      issue(0, 0, 12'h010, 32'd0, 4'h0, 32'h44332211, 1, 2);

      w0 = wr_cnt;
      issue(0, 1, 12'h020, 32'hDEADBEEF, 4'hF, 32'd0, 0, 3);
      chk("full_store_writes", wr_cnt - w0, 32'd1);
      chk("full_store_mem", mem[12'h020 >> 2], 32'hDEADBEEF);

      issue(1, 1, 12'h020, 32'h000000AA, 4'b0001, 32'hDEADBEEF, 1, 3);
      chk("byte0_store_mem", mem[12'h020 >> 2], 32'hDEADBEAA);

      issue(0, 1, 12'h020, 32'h11223344, 4'b1010, 32'hDEADBEAA, 1, 3);
      chk("mixed_be_mem", mem[12'h020 >> 2], 32'h11AD33AA);

      w0 = wr_cnt;
      issue(0, 1, 12'h030, 32'hFFFFFFFF, 4'h0, 32'h12345678, 1, 2);
      chk("be0_writes", wr_cnt - w0, 32'd0);
      chk("be0_mem", mem[12'h030 >> 2], 32'h12345678);

      issue(1, 0, 12'h010, 32'd0, 4'h0, 32'h44332211, 1, 2);

      // reset while the store sits in WRITE: nothing committed, no ack
      w0 = wr_cnt;
      @(negedge clk);
      a_we = 1; a_addr = 12'h050; a_wdata = 32'h55555555; a_be = 4'hF; a_req = 1'b1;
      @(negedge clk);
      a_req = 1'b0;
      chk("busy_in_read", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("write_en_in_write", {31'd0, ram_write_en}, 32'd1);
      rst = 1'b1;
      #1;
      chk("write_en_gated_by_rst", {31'd0, ram_write_en}, 32'd0);
      @(negedge clk);
      chk("rst_write_busy", {31'd0, busy}, 32'd0);
      chk("rst_write_ack", {30'd0, b_ack, a_ack}, 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_write_count", wr_cnt - w0, 32'd0);
      chk("rst_write_mem", mem[12'h050 >> 2], 32'h0BADF00D);

      // both held high straight after reset: A, B, A, B every 3 cycles
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         exp_t e;
         e.port = k[0]; e.chk_rdata = 1;
         e.rdata = k[0] ? 32'hB1B1B1B1 : 32'hA0A0A0A0;
         e.cyc = cyc + 2 + 3 * k;
         exp_q.push_back(e);
      end
      a_we = 0; a_addr = 12'h040; a_be = 4'h0;
      b_we = 0; b_addr = 12'h044; b_be = 4'h0;
      a_req = 1'b1; b_req = 1'b1;
      acks = 0;
      for (int i = 0; i < 40 && acks < 4; i++) begin
         @(negedge clk);
         if (a_ack || b_ack) acks++;
      end
      a_req = 1'b0; b_req = 1'b0;
      chk("rr_ack_count", acks, 32'd4);

      repeat (5) @(negedge clk);
      chk("pending_expect", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d expected=finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
